// File: rtl/demux1x4_stream_pkg.sv
// Shared types and sizing for the 1-to-N packet-aware stream demultiplexer.
// Optional per-lane beat statistics are built in when DEMUX1X4_STATS_EN is defined.
package demux1x4_stream_pkg;

   localparam int DATA_WIDTH_DEF = 4;
   localparam int SEL_WIDTH_DEF  = 2;
   localparam int NUM_OUT        = 1 << SEL_WIDTH_DEF;
   localparam int CNT_WIDTH      = 16;

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   function automatic int num_out(input int sel_width);
      return 1 << sel_width;
   endfunction

endpackage

// File: rtl/demux1x4_stream_if.sv
// Source-side and lane-side stream signals of the demultiplexer, grouped with
// master (traffic generator) and slave (demux) views.
interface demux1x4_stream_if
   import demux1x4_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int SEL_WIDTH  = SEL_WIDTH_DEF
);
   localparam int LANES = num_out(SEL_WIDTH);

   logic                        in_valid;
   logic                        in_ready;
   logic [DATA_WIDTH-1:0]       in_data;
   logic [SEL_WIDTH-1:0]        in_sel;
   logic                        in_last;
   logic [LANES-1:0]            out_valid;
   logic [LANES-1:0]            out_ready;
   logic [LANES*DATA_WIDTH-1:0] out_data;
   logic [LANES-1:0]            out_last;
   logic [LANES*CNT_WIDTH-1:0]  beat_cnt;

   modport master (
      output in_valid, in_data, in_sel, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, beat_cnt
   );

   modport slave (
      input  in_valid, in_data, in_sel, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, beat_cnt
   );

endinterface

// File: rtl/demux1x4_stream_chan_buf.sv
// One-entry lane holding register {valid,data,last}; a load wins over a drain
// so a simultaneous drain+fill keeps the lane valid without a bubble.
module demux1x4_stream_chan_buf #(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  drain,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  last
);

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   // NOTE: data/last are reset as well so idle lanes present all-zero payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         last  <= load_last;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux1x4_stream.sv
// Registered 1-to-N packet-aware stream demux: route locks on a packet's first
// beat until its last beat. DEMUX1X4_STATS_EN adds 16-bit per-lane beat counters.
module demux1x4_stream
   import demux1x4_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int SEL_WIDTH  = SEL_WIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   demux1x4_stream_if.slave  bus
);
   localparam int LANES = num_out(SEL_WIDTH);

   state_t                 state, state_nxt;
   logic [SEL_WIDTH-1:0]   lock_sel, lock_sel_nxt;
   logic [SEL_WIDTH-1:0]   route;
   logic                   accept;
   logic [LANES-1:0]       load, drain;
   logic [LANES-1:0]       lane_valid, lane_last;
   logic [DATA_WIDTH-1:0]  lane_data [LANES];

   assign route       = (state == IDLE) ? bus.in_sel : lock_sel;
   assign bus.in_ready = !lane_valid[route] || bus.out_ready[route];
   assign accept      = bus.in_valid && bus.in_ready;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign load[k]  = accept && (route == SEL_WIDTH'(k));
      assign drain[k] = lane_valid[k] && bus.out_ready[k];

      demux1x4_stream_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load[k]),
         .drain     (drain[k]),
         .load_data (bus.in_data),
         .load_last (bus.in_last),
         .valid     (lane_valid[k]),
         .data      (lane_data[k]),
         .last      (lane_last[k])
      );
   end

   assign bus.out_valid = lane_valid;
   assign bus.out_last  = lane_last;

   always_comb begin
      bus.out_data = '0;
      for (int k = 0; k < LANES; k++) begin
         bus.out_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_data[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         lock_sel <= '0;
      end else begin
         state    <= state_nxt;
         lock_sel <= lock_sel_nxt;
      end
   end

   // NOTE: defaults first so every path assigns the next-state signals (no latch).
   always_comb begin
      state_nxt    = state;
      lock_sel_nxt = lock_sel;
      case (state)
         IDLE: begin
            if (accept && !bus.in_last) begin
               state_nxt    = BURST;
               lock_sel_nxt = bus.in_sel;
            end
         end
         BURST: begin
            if (accept && bus.in_last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef DEMUX1X4_STATS_EN
   logic [CNT_WIDTH-1:0] cnt_q [LANES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LANES; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            if (load[k]) cnt_q[k] <= cnt_q[k] + CNT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      bus.beat_cnt = '0;
      for (int k = 0; k < LANES; k++) begin
         bus.beat_cnt[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
      end
   end
`else
   assign bus.beat_cnt = '0;
`endif

endmodule

// File: tb/tb_demux1x4_stream.sv
// Self-checking bench for demux1x4_stream: lane-slot model, per-cycle compare,
// directed reset/routing/lock/backpressure/stats vectors and a random phase.
module tb_demux1x4_stream;

   localparam int DW = 4;
   localparam int SW = 2;
   localparam int NO = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   demux1x4_stream_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

   demux1x4_stream #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each lane holds at most one beat; a packet sticks to its first beat's lane.
   bit             m_full [NO];
   logic [DW-1:0]  m_data [NO];
   bit             m_last [NO];
   int             m_cnt  [NO];
   bit             m_mid;
   int             m_lane;
   int             m_accepted = 0;
   int             drained    = 0;
   bit             cmp_en     = 1'b0;

   function automatic int route_of();
      return m_mid ? m_lane : int'(bus.in_sel);
   endfunction

   function automatic bit exp_ready();
      int r;
      r = route_of();
      return !m_full[r] || bus.out_ready[r];
   endfunction

   initial forever begin : model
      int r;
      bit acc;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         for (int k = 0; k < NO; k++) begin
            m_full[k] = 1'b0; m_data[k] = '0; m_last[k] = 1'b0; m_cnt[k] = 0;
         end
         m_mid  = 1'b0;
         m_lane = 0;
      end else begin
         r   = route_of();
         acc = bus.in_valid && exp_ready();
         for (int k = 0; k < NO; k++) begin
            if (m_full[k] && bus.out_ready[k]) m_full[k] = 1'b0;
         end
         if (acc) begin
            m_full[r] = 1'b1;
            m_data[r] = bus.in_data;
            m_last[r] = bus.in_last;
            m_cnt[r]  = (m_cnt[r] + 1) % 65536;
            m_accepted++;
            if (!m_mid && !bus.in_last) begin
               m_mid  = 1'b1;
               m_lane = r;
            end else if (m_mid && bus.in_last) begin
               m_mid = 1'b0;
            end
         end
      end
   end

   initial forever begin : compare
      logic [NO-1:0] ev;
      @(negedge clk);
      if (rst_n && cmp_en) begin
         for (int k = 0; k < NO; k++) ev[k] = m_full[k];
         check("in_ready", 64'(bus.in_ready), 64'(exp_ready()));
         check("out_valid", 64'(bus.out_valid), 64'(ev));
         for (int k = 0; k < NO; k++) begin
            if (m_full[k]) begin
               check("out_data", 64'(bus.out_data[k*DW +: DW]), 64'(m_data[k]));
               check("out_last", 64'(bus.out_last[k]), 64'(m_last[k]));
            end
`ifdef DEMUX1X4_STATS_EN
            check("beat_cnt", 64'(bus.beat_cnt[k*16 +: 16]), 64'(m_cnt[k]));
`endif
            if (bus.out_valid[k] && bus.out_ready[k]) drained++;
         end
`ifndef DEMUX1X4_STATS_EN
         check("beat_cnt_off", bus.beat_cnt, 64'd0);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input int sel, input int data, input bit last);
      bus.in_valid = v;
      bus.in_sel   = SW'(sel);
      bus.in_data  = DW'(data);
      bus.in_last  = last;
   endtask

   task automatic do_reset();
      step();
      rst_n = 1'b0;
      drive(0, 0, 0, 0);
      step();
      rst_n = 1'b1;
   endtask

   int t3_sel  [4] = '{1, 3, 3, 3};
   int t3_lane [4] = '{1, 1, 1, 3};
   bit t3_last [4] = '{0, 0, 1, 1};
   int base_acc, base_dr;
   bit last_acc;

   initial begin
      drive(0, 0, 0, 0);
      bus.out_ready = '1;
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", 64'(bus.out_data), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_beat_cnt", bus.beat_cnt, 64'd0);
      step();

      // Single-beat packets to each lane, one per clock.
      for (int i = 0; i <= 4; i++) begin
         if (i < 4) drive(1, i, 10 + i, 1);
         else       drive(0, 0, 0, 0);
         @(negedge clk);
         if (i < 4) check("t2_in_ready", 64'(bus.in_ready), 64'd1);
         if (i > 0) begin
            check("t2_lane_valid", 64'(bus.out_valid), 64'(1 << (i - 1)));
            check("t2_lane_data", 64'(bus.out_data[(i-1)*DW +: DW]), 64'(10 + i - 1));
         end
         step();
      end

      // Route lock: in_sel ignored after the first beat until in_last.
      for (int i = 0; i <= 4; i++) begin
         if (i < 4) drive(1, t3_sel[i], i + 1, t3_last[i]);
         else       drive(0, 0, 0, 0);
         @(negedge clk);
         if (i > 0) begin
            check("t3_lane_valid", 64'(bus.out_valid), 64'(1 << t3_lane[i-1]));
            check("t3_lane_data", 64'(bus.out_data[t3_lane[i-1]*DW +: DW]), 64'(i));
            check("t3_lane_last", 64'(bus.out_last[t3_lane[i-1]]), 64'(t3_last[i-1]));
         end
         step();
      end

      // Backpressure on lane 2 only.
      bus.out_ready = 4'b1011;
      drive(1, 2, 5, 1);
      @(negedge clk);
      check("t4_first_ready", 64'(bus.in_ready), 64'd1);
      step();
      drive(1, 0, 7, 1);
      @(negedge clk);
      check("t4_other_lane_ready", 64'(bus.in_ready), 64'd1);
      step();
      drive(1, 2, 6, 1);
      repeat (2) begin
         @(negedge clk);
         check("t4_stall_ready", 64'(bus.in_ready), 64'd0);
         check("t4_hold_data", 64'(bus.out_data[2*DW +: DW]), 64'd5);
         step();
      end
      bus.out_ready = 4'b1111;
      @(negedge clk);
      check("t4_release_ready", 64'(bus.in_ready), 64'd1);
      step();
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("t4_no_bubble_valid", 64'(bus.out_valid[2]), 64'd1);
      check("t4_no_bubble_data", 64'(bus.out_data[2*DW +: DW]), 64'd6);
      step();

      // Reset mid-packet with lane 2 full discards the beat and the lock.
      bus.out_ready = 4'b1011;
      drive(1, 2, 9, 0);
      step();
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("t1_lane2_full", 64'(bus.out_valid), 64'b0100);
      #2 rst_n = 1'b0;
      #1;
      check("t1_rst_valid", 64'(bus.out_valid), 64'd0);
      step();
      rst_n = 1'b1;
      bus.out_ready = 4'b1111;
      drive(1, 1, 3, 1);
      step();
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("t1_reroute_valid", 64'(bus.out_valid), 64'b0010);
      check("t1_reroute_data", 64'(bus.out_data[1*DW +: DW]), 64'd3);
      step();

`ifdef DEMUX1X4_STATS_EN
      // Counter wrap on lane 3 after 0x10000 accepted beats.
      do_reset();
      drive(1, 3, 14, 1);
      repeat (65535) step();
      @(negedge clk);
      check("t5_cnt_ffff", 64'(bus.beat_cnt[63:48]), 64'hFFFF);
      check("t5_cnt_others", 64'(bus.beat_cnt[47:0]), 64'd0);
      step();
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("t5_cnt_wrap", bus.beat_cnt, 64'd0);
      step();
`else
      @(negedge clk);
      check("t5_cnt_absent", bus.beat_cnt, 64'd0);
      step();
`endif

      // Random valid/ready; source holds a stalled beat until accepted.
      drive(0, 0, 0, 0);
      step();
      base_acc = m_accepted;
      base_dr  = drained;
      last_acc = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (!bus.in_valid || last_acc) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 15),
                  $urandom_range(0, 9) < 3);
         end
         bus.out_ready = NO'($urandom);
         @(negedge clk);
         last_acc = bus.in_valid && bus.in_ready;
         step();
      end
      drive(0, 0, 0, 0);
      bus.out_ready = '1;
      repeat (3) step();
      @(negedge clk);
      check("t6_all_drained", 64'(bus.out_valid), 64'd0);
      check("t6_no_loss_dup", 64'(drained - base_dr), 64'(m_accepted - base_acc));
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
